// File: rtl/sync_fifo_param.sv
// sync_fifo_param -- parametrised single-clock FIFO for the UART register block.
//   Configurable width/depth, optional show-ahead read, almost-full/almost-empty
//   thresholds, full-range fill count and sticky overflow/underflow flags.
// Ports:
//   clock, sclr         rising-edge clock, synchronous active-high reset
//   data, wrreq         write data / write request
//   rdreq               read request (show-ahead: pop the head word)
//   clr_err             synchronous clear of overflow/underflow
//   q                   read data (registered)
//   full, empty         usedw == DEPTH / usedw == 0
//   almost_full/_empty  usedw >= AF_LEVEL / usedw <= AE_LEVEL
//   usedw               stored word count, 0..DEPTH
//   overflow, underflow sticky error flags
module sync_fifo_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int SHOWAHEAD  = 0,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clock,
    input  logic                  sclr,
    input  logic [WIDTH-1:0]      data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      q,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   usedw,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_usedw;
    logic [WIDTH-1:0] r_q;
    logic             r_full, r_empty, r_af, r_ae, r_ovf, r_unf;

    logic             w_rd_ok, w_wr_ok;
    logic [CW-1:0]    w_cnt_nxt;
    logic [AW-1:0]    w_rd_ptr_p1;
    logic [WIDTH-1:0] w_q_nxt;

    // A read frees a slot in the same edge, so a write at full is accepted
    // alongside it.
    assign w_rd_ok     = rdreq & ~r_empty;
    assign w_wr_ok     = wrreq & (~r_full | w_rd_ok);
    assign w_cnt_nxt   = r_usedw + CW'(w_wr_ok) - CW'(w_rd_ok);
    assign w_rd_ptr_p1 = r_rd_ptr + AW'(1);

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            // q always mirrors the head word. A write into an empty FIFO
            // becomes the head; a pop exposes the next stored word, or the
            // word written this cycle when only one was left; otherwise hold.
            always_comb begin
                w_q_nxt = r_q;
                if (w_wr_ok && r_empty)
                    w_q_nxt = data;
                else if (w_rd_ok) begin
                    if (r_usedw > CW'(1))
                        w_q_nxt = r_mem[w_rd_ptr_p1];
                    else if (w_wr_ok)
                        w_q_nxt = data;
                end
            end
        end else begin : g_normal
            always_comb begin
                w_q_nxt = r_q;
                if (w_rd_ok)
                    w_q_nxt = r_mem[r_rd_ptr];
            end
        end
    endgenerate

    // Storage has no reset; writes in the reset cycle are dropped.
    always_ff @(posedge clock) begin
        if (!sclr && w_wr_ok)
            r_mem[r_wr_ptr] <= data;
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_q      <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_ok) r_rd_ptr <= w_rd_ptr_p1;
            r_usedw <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_full  <= (w_cnt_nxt == C_FULL);
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= C_AF);
            r_ae    <= (w_cnt_nxt <= C_AE);
            // A fresh error in the clear cycle keeps the flag set.
            r_ovf   <= (r_ovf & ~clr_err) | (wrreq & ~w_wr_ok);
            r_unf   <= (r_unf & ~clr_err) | (rdreq & r_empty);
        end
    end

    assign q            = r_q;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign usedw        = r_usedw;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
    logic       clock = 1'b0;
    logic       sclr;
    logic [7:0] data;
    logic       wrreq, rdreq, clr_err;
    logic [7:0] q;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] usedw;

    logic [7:0] sa_data;
    logic       sa_wrreq, sa_rdreq, sa_clr_err;
    logic [7:0] sa_q;
    logic       sa_full, sa_empty, sa_af, sa_ae, sa_ovf, sa_unf;
    logic [4:0] sa_usedw;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    logic [7:0] exp_q;
    logic       exp_ovf, exp_unf;

    always #5 clock = ~clock;

    sync_fifo_param #(.WIDTH(8), .DEPTH_LOG2(4), .SHOWAHEAD(0), .AF_LEVEL(12), .AE_LEVEL(2)) u_dut (
        .clock(clock), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq), .clr_err(clr_err),
        .q(q), .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .usedw(usedw), .overflow(overflow), .underflow(underflow));

    sync_fifo_param #(.WIDTH(8), .DEPTH_LOG2(4), .SHOWAHEAD(1), .AF_LEVEL(12), .AE_LEVEL(2)) u_sa (
        .clock(clock), .sclr(sclr), .data(sa_data), .wrreq(sa_wrreq), .rdreq(sa_rdreq), .clr_err(sa_clr_err),
        .q(sa_q), .full(sa_full), .empty(sa_empty), .almost_full(sa_af), .almost_empty(sa_ae),
        .usedw(sa_usedw), .overflow(sa_ovf), .underflow(sa_unf));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".q"},     32'(q),            32'(exp_q));
        chk({tag, ".usedw"}, 32'(usedw),        32'(sb.size()));
        chk({tag, ".full"},  32'(full),         32'(sb.size() == 16));
        chk({tag, ".empty"}, 32'(empty),        32'(sb.size() == 0));
        chk({tag, ".af"},    32'(almost_full),  32'(sb.size() >= 12));
        chk({tag, ".ae"},    32'(almost_empty), 32'(sb.size() <= 2));
        chk({tag, ".ovf"},   32'(overflow),     32'(exp_ovf));
        chk({tag, ".unf"},   32'(underflow),    32'(exp_unf));
    endtask

    // One cycle on the normal-mode FIFO, with the scoreboard advanced alongside.
    task automatic op(input bit wr, input bit rd, input bit clr, input logic [7:0] d, input string tag);
        bit rd_ok, wr_ok, was_empty;
        was_empty = (sb.size() == 0);
        rd_ok = rd && !was_empty;
        wr_ok = wr && ((sb.size() < 16) || rd_ok);
        wrreq = wr; rdreq = rd; clr_err = clr; data = d;
        tick();
        wrreq = 1'b0; rdreq = 1'b0; clr_err = 1'b0;
        if (rd_ok) exp_q = sb.pop_front();
        if (wr_ok) sb.push_back(d);
        exp_ovf = (exp_ovf & !clr) | (wr & !wr_ok);
        exp_unf = (exp_unf & !clr) | (rd & was_empty);
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        sclr = 1'b1; wrreq = 1'b1; rdreq = 1'b1; data = 8'hEE;
        tick();
        sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
        sb.delete();
        exp_q = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        sclr = 1'b0; data = 8'h00; wrreq = 1'b0; rdreq = 1'b0; clr_err = 1'b0;
        sa_data = 8'h00; sa_wrreq = 1'b0; sa_rdreq = 1'b0; sa_clr_err = 1'b0;
        exp_q = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
        tick();

        // Reset state
        do_reset("rst");
        chk("rst.sa_q", 32'(sa_q), 32'h0);
        chk("rst.sa_empty", 32'(sa_empty), 32'h1);

        // Fill to full, then one dropped write
        for (int i = 1; i <= 16; i++) op(1'b1, 1'b0, 1'b0, 8'(i), "fill");
        op(1'b1, 1'b0, 1'b0, 8'hFF, "ovf_drop");

        // Simultaneous read/write at full: count stays 16, head comes out
        op(1'b1, 1'b1, 1'b0, 8'hAA, "simul_full");
        chk("simul_full.q01", 32'(q), 32'h01);

        // Drain: 0x02..0x10 then 0xAA
        for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 1'b0, 8'h00, "drain");
        chk("drain.last_aa", 32'(q), 32'hAA);

        // Underflow on empty, q holds; write+read on empty takes the write only
        op(1'b0, 1'b1, 1'b1, 8'h00, "unf_clr_ovf");
        op(1'b1, 1'b1, 1'b0, 8'h42, "unf_wr_rd");
        op(1'b0, 1'b0, 1'b1, 8'h00, "clr_err");
        op(1'b0, 1'b1, 1'b0, 8'h00, "rd_42");

        // Random interleaved traffic, enough writes to wrap the pointers twice
        for (int i = 0; i < 40; i++)
            op(1'b1, (i >= 3) && ($urandom_range(0, 3) != 0), 1'b0, 8'($urandom), "rand");
        while (sb.size() > 7) op(1'b0, 1'b1, 1'b0, 8'h00, "trim");
        while (sb.size() < 7) op(1'b1, 1'b0, 1'b0, 8'($urandom), "pad");
        chk("pre_rst.usedw7", 32'(usedw), 32'd7);

        // Reset mid-operation discards stored words and the requests of that cycle
        do_reset("mid_rst");
        op(1'b1, 1'b0, 1'b0, 8'h33, "post_rst_wr");
        op(1'b0, 1'b1, 1'b0, 8'h00, "post_rst_rd");
        chk("post_rst.q33", 32'(q), 32'h33);

        // Show-ahead instance
        sa_data = 8'h5A; sa_wrreq = 1'b1; tick(); sa_wrreq = 1'b0;
        chk("sa.wr_empty", 32'(sa_empty), 32'h0);
        chk("sa.wr_q5a", 32'(sa_q), 32'h5A);
        sa_rdreq = 1'b1; tick(); sa_rdreq = 1'b0;
        chk("sa.rd_empty", 32'(sa_empty), 32'h1);
        chk("sa.rd_qhold", 32'(sa_q), 32'h5A);
        sa_data = 8'h11; sa_wrreq = 1'b1; tick();
        sa_data = 8'h22; tick(); sa_wrreq = 1'b0;
        chk("sa.two_q", 32'(sa_q), 32'h11);
        chk("sa.two_usedw", 32'(sa_usedw), 32'd2);
        sa_rdreq = 1'b1; tick(); sa_rdreq = 1'b0;
        chk("sa.pop_q", 32'(sa_q), 32'h22);
        sa_data = 8'h33; sa_wrreq = 1'b1; sa_rdreq = 1'b1; tick();
        sa_wrreq = 1'b0; sa_rdreq = 1'b0;
        chk("sa.last_rdwr_q", 32'(sa_q), 32'h33);
        chk("sa.last_rdwr_empty", 32'(sa_empty), 32'h0);
        sa_rdreq = 1'b1; tick(); sa_rdreq = 1'b0;
        chk("sa.drain_empty", 32'(sa_empty), 32'h1);
        chk("sa.drain_q", 32'(sa_q), 32'h33);
        chk("sa.no_unf", 32'(sa_unf), 32'h0);
        sa_data = 8'h77; sa_wrreq = 1'b1; sa_rdreq = 1'b1; tick();
        sa_wrreq = 1'b0; sa_rdreq = 1'b0;
        chk("sa.empty_rdwr_unf", 32'(sa_unf), 32'h1);
        chk("sa.empty_rdwr_q", 32'(sa_q), 32'h77);
        chk("sa.empty_rdwr_usedw", 32'(sa_usedw), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
